// File: rtl/cluster_clock_gate_ctrl.sv
// Always-on controller that drives the cluster clock gate enable: idle detection,
// stop req/ack handshake with the cluster, gating, and wake with a settle delay.
module cluster_clock_gate_ctrl #(
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_enable_i,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thresh_i,
    input  logic                  busy_i,
    input  logic                  wake_req_i,
    input  logic                  stop_ack_i,
    output logic                  stop_req_o,
    output logic                  gate_en_o,
    output logic                  gated_o,
    output logic [15:0]           gate_cnt_o
);

    localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_RUN,
        S_STOP_REQ,
        S_GATED,
        S_WAKE,
        S_RELEASE
    } state_e;

    state_e                  state_q, state_d;
    logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                    pend_q, pend_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic [15:0]             gate_cnt_q, gate_cnt_d;
    logic                    stop_req_q, gate_en_q, gated_q;

    logic                    idle;
    logic                    wake_cond;
    logic                    pend_now;
    logic [IDLE_CNT_W-1:0]   idle_inc;
    logic [IDLE_CNT_W-1:0]   thresh_eff;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        pend_d     = pend_q;
        wcnt_d     = wcnt_q;
        gate_cnt_d = gate_cnt_q;

        idle       = !busy_i && !wake_req_i && cfg_enable_i;
        wake_cond  = wake_req_i || busy_i || !cfg_enable_i;
        pend_now   = pend_q || wake_cond;
        idle_inc   = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
        // The compare uses the post-increment count, so threshold 0 must act as 1.
        thresh_eff = (cfg_idle_thresh_i == '0) ? IDLE_CNT_W'(1) : cfg_idle_thresh_i;

        case (state_q)
            S_RUN: begin
                if (idle) begin
                    idle_cnt_d = idle_inc;
                    if (idle_inc == thresh_eff) begin
                        state_d    = S_STOP_REQ;
                        idle_cnt_d = '0;
                        pend_d     = 1'b0;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            S_STOP_REQ: begin
                pend_d = pend_now;
                if (stop_ack_i) begin
                    if (pend_now) begin
                        state_d = S_WAKE;
                        wcnt_d  = '0;
                    end else begin
                        state_d    = S_GATED;
                        gate_cnt_d = (gate_cnt_q == 16'hFFFF) ? gate_cnt_q : gate_cnt_q + 16'd1;
                    end
                end
            end
            S_GATED: begin
                if (wake_cond) begin
                    state_d = S_WAKE;
                    wcnt_d  = '0;
                end
            end
            S_WAKE: begin
                if (wcnt_q == WCNT_W'(WAKE_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!stop_ack_i) begin
                    state_d    = S_RUN;
                    idle_cnt_d = '0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_RUN;
            idle_cnt_q <= '0;
            pend_q     <= 1'b0;
            wcnt_q     <= '0;
            gate_cnt_q <= '0;
            stop_req_q <= 1'b0;
            gate_en_q  <= 1'b1;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            pend_q     <= pend_d;
            wcnt_q     <= wcnt_d;
            gate_cnt_q <= gate_cnt_d;
            stop_req_q <= (state_d == S_STOP_REQ) || (state_d == S_GATED) || (state_d == S_WAKE);
            gate_en_q  <= (state_d != S_GATED);
            gated_q    <= (state_d == S_GATED);
        end
    end

    assign stop_req_o = stop_req_q;
    assign gate_en_o  = gate_en_q;
    assign gated_o    = gated_q;
    assign gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Bench for cluster_clock_gate_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cluster_clock_gate_ctrl;

    localparam int IW   = 8;
    localparam int WAKE = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_enable_i = 1'b1;
    logic [IW-1:0] cfg_idle_thresh_i = 8'd5;
    logic          busy_i = 1'b0;
    logic          wake_req_i = 1'b0;
    logic          stop_ack_i = 1'b0;
    logic          stop_req_o, gate_en_o, gated_o;
    logic [15:0]   gate_cnt_o;

    int checks = 0;
    int failures = 0;

    // cluster-side acknowledge behaviour
    bit ack_auto = 1'b1;
    bit ack_force_val = 1'b0;
    int ack_delay = 2;

    cluster_clock_gate_ctrl #(.IDLE_CNT_W(IW), .WAKE_CYCLES(WAKE)) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_enable_i(cfg_enable_i),
        .cfg_idle_thresh_i(cfg_idle_thresh_i), .busy_i(busy_i), .wake_req_i(wake_req_i),
        .stop_ack_i(stop_ack_i), .stop_req_o(stop_req_o), .gate_en_o(gate_en_o),
        .gated_o(gated_o), .gate_cnt_o(gate_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Cluster model: ack follows req after ack_delay cycles of disagreement.
    initial begin
        int acnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!ack_auto) begin
                stop_ack_i = ack_force_val;
                acnt = 0;
            end else if (stop_req_o != stop_ack_i) begin
                acnt++;
                if (acnt >= ack_delay) begin
                    stop_ack_i = stop_req_o;
                    acnt = 0;
                end
            end else begin
                acnt = 0;
            end
        end
    end

    // Behavioural reference: phase 0 run, 1 requesting, 2 gated, 3 waking, 4 releasing.
    int  m_phase = 0;
    int  m_idle = 0;
    bit  m_pend = 0;
    int  m_wleft = 0;
    int  m_cnt = 0;
    bit  m_valid = 0;

    initial begin
        int thr;
        bit wakeish;
        forever begin
            @(posedge clk);
            wakeish = busy_i || wake_req_i || !cfg_enable_i;
            if (rst_i) begin
                m_phase = 0; m_idle = 0; m_pend = 0; m_wleft = 0; m_cnt = 0; m_valid = 1;
            end else if (m_phase == 0) begin
                if (wakeish) m_idle = 0;
                else begin
                    m_idle = (m_idle >= (1 << IW) - 1) ? (1 << IW) - 1 : m_idle + 1;
                    thr = (cfg_idle_thresh_i == 0) ? 1 : int'(cfg_idle_thresh_i);
                    if (m_idle == thr) begin m_phase = 1; m_pend = 0; m_idle = 0; end
                end
            end else if (m_phase == 1) begin
                if (wakeish) m_pend = 1;
                if (stop_ack_i) begin
                    if (m_pend) begin m_phase = 3; m_wleft = WAKE; end
                    else begin m_phase = 2; if (m_cnt < 65535) m_cnt++; end
                end
            end else if (m_phase == 2) begin
                if (wakeish) begin m_phase = 3; m_wleft = WAKE; end
            end else if (m_phase == 3) begin
                m_wleft--;
                if (m_wleft == 0) m_phase = 4;
            end else begin
                if (!stop_ack_i) begin m_phase = 0; m_idle = 0; end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("model_gate_en", gate_en_o, (m_phase != 2));
                chk("model_stop_req", stop_req_o, (m_phase >= 1 && m_phase <= 3));
                chk("model_gated", gated_o, (m_phase == 2));
                chk("model_gate_cnt", gate_cnt_o, m_cnt);
            end
        end
    end

    initial begin
        int n;
        bit seen;
        step(); step();
        chk("reset_gate_en", gate_en_o, 1);
        chk("reset_stop_req", stop_req_o, 0);
        chk("reset_gated", gated_o, 0);
        chk("reset_gate_cnt", gate_cnt_o, 0);
        rst_i = 1'b0;

        // idle from reset with threshold 5
        n = 0;
        while (!stop_req_o && n < 50) begin step(); n++; end
        chk("req_after_5_idle", n, 5);
        n = 0;
        seen = 0;
        for (int i = 0; i < 50 && gate_en_o; i++) begin
            if (stop_ack_i) n++;
            step();
        end
        chk("gate_fall_after_ack", n, 1);
        chk("gated_status", gated_o, 1);
        chk("gate_cnt_first", gate_cnt_o, 1);

        // single-cycle wake pulse while gated
        step(); step();
        wake_req_i = 1'b1;
        step();
        wake_req_i = 1'b0;
        chk("wake_gate_en", gate_en_o, 1);
        n = 0;
        while (stop_req_o && n < 50) begin step(); n++; end
        chk("req_drop_after_wake", n, WAKE);

        // busy toggling every 3 cycles never reaches threshold 5
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            busy_i = ((i / 3) % 2) == 0;
            step();
            if (stop_req_o) seen = 1;
        end
        chk("busy_toggle_no_req", seen, 0);
        chk("busy_toggle_cnt", gate_cnt_o, 1);

        // wake during the request phase with a slow acknowledge
        busy_i = 1'b0;
        ack_delay = 10;
        n = 0;
        while (!stop_req_o && n < 50) begin step(); n++; end
        wake_req_i = 1'b1;
        step(); step();
        wake_req_i = 1'b0;
        seen = 0;
        n = 0;
        while ((stop_req_o || stop_ack_i) && n < 100) begin
            if (!gate_en_o) seen = 1;
            step(); n++;
        end
        busy_i = 1'b1;
        chk("stopreq_wake_gate_held", seen, 0);
        chk("stopreq_wake_flow_done", (n < 100), 1);
        chk("stopreq_wake_cnt", gate_cnt_o, 1);

        // clearing the enable while gated
        ack_delay = 2;
        step();
        busy_i = 1'b0;
        n = 0;
        while (!gated_o && n < 100) begin step(); n++; end
        chk("regated_cnt", gate_cnt_o, 2);
        cfg_enable_i = 1'b0;
        step();
        chk("disable_gate_en", gate_en_o, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (gated_o || !gate_en_o) seen = 1;
        end
        chk("disable_no_gating", seen, 0);
        chk("disable_req_low", stop_req_o, 0);

        // reset while gated with the acknowledge held high
        cfg_enable_i = 1'b1;
        n = 0;
        while (!gated_o && n < 100) begin step(); n++; end
        chk("gated_before_reset", gated_o, 1);
        ack_force_val = 1'b1;
        ack_auto = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        chk("rst_gate_en", gate_en_o, 1);
        chk("rst_stop_req", stop_req_o, 0);
        chk("rst_gate_cnt", gate_cnt_o, 0);
        rst_i = 1'b0;
        ack_force_val = 1'b0;
        ack_auto = 1'b1;
        cfg_idle_thresh_i = 8'd0;
        n = 0;
        while (!stop_req_o && n < 50) begin step(); n++; end
        chk("thresh0_req_after_1", n, 1);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            busy_i = ($urandom_range(7) == 0);
            wake_req_i = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) cfg_enable_i = ~cfg_enable_i;
            if ($urandom_range(49) == 0) cfg_idle_thresh_i = IW'($urandom_range(6));
            if ($urandom_range(99) == 0) ack_delay = $urandom_range(4, 1);
            rst_i = ($urandom_range(499) == 0);
            step();
        end
        rst_i = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
